// File: rtl/bus_router.sv
// Registered address-decoding router: one master to TARGETS slaves, base-relative addressing.
// Latency: 2 edges minimum (1 for unmapped); master holds i_request until o_ready, and a drop in ACTIVE aborts.
module bus_router #(
    parameter int                    TARGETS = 4,
    parameter logic [32*TARGETS-1:0] BASES   = {TARGETS{32'h0}},
    parameter logic [32*TARGETS-1:0] LIMITS  = {TARGETS{32'h0}},
    parameter int                    TIMEOUT = 1024
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_request,
    input  logic                    i_rw,
    input  logic [31:0]             i_address,
    input  logic [31:0]             i_wdata,
    output logic [31:0]             o_rdata,
    output logic                    o_ready,
    output logic                    o_error,
    output logic [TARGETS-1:0]      o_target_request,
    output logic                    o_target_rw,
    output logic [31:0]             o_target_address,
    output logic [31:0]             o_target_wdata,
    input  logic [32*TARGETS-1:0]   i_target_rdata,
    input  logic [TARGETS-1:0]      i_target_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RESPOND
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_count;
    logic [31:0]          r_rdata;
    logic                 r_ready;
    logic                 r_error;
    logic [TARGETS-1:0]   r_target_request;
    logic                 r_target_rw;
    logic [31:0]          r_target_address;
    logic [31:0]          r_target_wdata;

    logic                 w_hit;
    logic [TARGETS-1:0]   w_hit_oh;
    logic [31:0]          w_hit_base;
    logic                 w_sel_ready;
    logic [31:0]          w_sel_rdata;
    logic                 w_timeout;

    // Walk from the top index down so the lowest matching region overwrites the rest.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_oh   = '0;
        w_hit_base = '0;
        for (int i = TARGETS - 1; i >= 0; i--) begin
            if (i_address >= BASES[32*i +: 32] && i_address < LIMITS[32*i +: 32]) begin
                w_hit       = 1'b1;
                w_hit_oh    = '0;
                w_hit_oh[i] = 1'b1;
                w_hit_base  = BASES[32*i +: 32];
            end
        end
    end

    // The latched one-hot request doubles as the response mux select.
    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < TARGETS; i++) begin
            if (r_target_request[i]) begin
                w_sel_rdata = i_target_rdata[32*i +: 32];
            end
        end
    end

    assign w_sel_ready = |(i_target_ready & r_target_request);
    assign w_timeout   = (TIMEOUT != 0) && (r_count == LAST_COUNT);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= S_IDLE;
            r_count          <= '0;
            r_rdata          <= '0;
            r_ready          <= 1'b0;
            r_error          <= 1'b0;
            r_target_request <= '0;
            r_target_rw      <= 1'b0;
            r_target_address <= '0;
            r_target_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_request) begin
                        if (w_hit) begin
                            r_state          <= S_ACTIVE;
                            r_count          <= '0;
                            r_target_request <= w_hit_oh;
                            r_target_rw      <= i_rw;
                            r_target_address <= i_address - w_hit_base;
                            r_target_wdata   <= i_wdata;
                        end else begin
                            r_state <= S_RESPOND;
                            r_ready <= 1'b1;
                            r_error <= 1'b1;
                            r_rdata <= '0;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!i_request) begin
                        r_state          <= S_IDLE;
                        r_target_request <= '0;
                    end else if (w_sel_ready) begin
                        r_state          <= S_RESPOND;
                        r_ready          <= 1'b1;
                        r_error          <= 1'b0;
                        r_rdata          <= w_sel_rdata;
                        r_target_request <= '0;
                    end else if (w_timeout) begin
                        r_state          <= S_RESPOND;
                        r_ready          <= 1'b1;
                        r_error          <= 1'b1;
                        r_rdata          <= '0;
                        r_target_request <= '0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_RESPOND: begin
                    if (!i_request) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rdata          = r_rdata;
    assign o_ready          = r_ready;
    assign o_error          = r_error;
    assign o_target_request = r_target_request;
    assign o_target_rw      = r_target_rw;
    assign o_target_address = r_target_address;
    assign o_target_wdata   = r_target_wdata;

endmodule

// File: tb/tb_bus_router.sv
// Randomized and directed transactions against a transaction-level model of the router.
module tb_bus_router;

    localparam int NT = 4;
    localparam int TO = 16;
    localparam logic [32*NT-1:0] P_BASES  = {32'h20000000, 32'h10000000, 32'h00010000, 32'h00000000};
    localparam logic [32*NT-1:0] P_LIMITS = {32'h40000000, 32'h20000000, 32'h00020000, 32'h00010000};

    logic [31:0] m_base  [NT] = '{32'h00000000, 32'h00010000, 32'h10000000, 32'h20000000};
    logic [31:0] m_limit [NT] = '{32'h00010000, 32'h00020000, 32'h20000000, 32'h40000000};

    logic               clk;
    logic               i_reset;
    logic               i_request;
    logic               i_rw;
    logic [31:0]        i_address;
    logic [31:0]        i_wdata;
    logic [31:0]        o_rdata;
    logic               o_ready;
    logic               o_error;
    logic [NT-1:0]      o_target_request;
    logic               o_target_rw;
    logic [31:0]        o_target_address;
    logic [31:0]        o_target_wdata;
    logic [32*NT-1:0]   i_target_rdata;
    logic [NT-1:0]      i_target_ready;

    // Second instance with overlapping regions: 0 covers 0x0-0x1000, 1 covers 0x0-0x200.
    logic [31:0]        ov_rdata;
    logic               ov_ready;
    logic               ov_error;
    logic [1:0]         ov_treq;
    logic               ov_trw;
    logic [31:0]        ov_taddr;
    logic [31:0]        ov_twdata;

    int          n_checks = 0;
    int          n_err    = 0;
    logic        chk_en   = 1'b0;
    logic        exp_ready, exp_error, exp_rw;
    logic [31:0] exp_rdata, exp_taddr, exp_wdata;
    logic [NT-1:0] exp_req;

    int          last_lat;
    logic [31:0] last_taddr, last_twdata, last_rdata;
    logic [NT-1:0] last_treq;
    logic        last_trw, last_err, last_rdy;
    logic [1:0]  last_ovreq;

    bus_router #(.TARGETS(NT), .BASES(P_BASES), .LIMITS(P_LIMITS), .TIMEOUT(TO)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
        .i_address(i_address), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready),
        .o_error(o_error), .o_target_request(o_target_request), .o_target_rw(o_target_rw),
        .o_target_address(o_target_address), .o_target_wdata(o_target_wdata),
        .i_target_rdata(i_target_rdata), .i_target_ready(i_target_ready)
    );

    bus_router #(.TARGETS(2), .BASES({32'h0, 32'h0}), .LIMITS({32'h200, 32'h1000}), .TIMEOUT(TO)) dut_ov (
        .i_clock(clk), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
        .i_address(i_address), .i_wdata(i_wdata), .o_rdata(ov_rdata), .o_ready(ov_ready),
        .o_error(ov_error), .o_target_request(ov_treq), .o_target_rw(ov_trw),
        .o_target_address(ov_taddr), .o_target_wdata(ov_twdata),
        .i_target_rdata({32'hBBBB0001, 32'hAAAA0000}), .i_target_ready(ov_treq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NT; i++) begin
            if (a >= m_base[i] && a < m_limit[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(o_ready), 32'(exp_ready));
            chk("error", 32'(o_error), 32'(exp_error));
            chk("treq",  32'(o_target_request), 32'(exp_req));
            if (exp_ready) chk("rdata", o_rdata, exp_rdata);
            if (exp_req != '0) begin
                chk("taddr",  o_target_address, exp_taddr);
                chk("trw",    32'(o_target_rw), 32'(exp_rw));
                chk("twdata", o_target_wdata, exp_wdata);
            end
        end
    end

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 5);
        if (r < NT) return m_base[r] + ($urandom % (m_limit[r] - m_base[r]));
        if (r == 4) return {2'b01, 30'($urandom)};
        return $urandom;
    endfunction

    // Called #1 after an edge with the router idle; returns #1 after the router is idle again.
    task automatic do_txn(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                          input int delay, input int abort_at, input logic [31:0] rd_val,
                          input int hold);
        int idx;
        int n;
        logic done;
        logic aborted;
        idx = decode(addr);
        i_request = 1'b1; i_rw = rw; i_address = addr; i_wdata = wd;
        i_target_ready = '0;
        for (int t = 0; t < NT; t++) i_target_rdata[32*t +: 32] = $urandom;
        if (idx >= 0) i_target_rdata[32*idx +: 32] = rd_val;
        @(posedge clk); #1;
        last_treq = o_target_request; last_taddr = o_target_address;
        last_trw = o_target_rw; last_twdata = o_target_wdata; last_ovreq = ov_treq;
        aborted = 1'b0;
        n = 1;
        if (idx < 0) begin
            exp_ready = 1'b1; exp_error = 1'b1; exp_rdata = '0; exp_req = '0;
        end else begin
            exp_req = '0; exp_req[idx] = 1'b1;
            exp_taddr = addr - m_base[idx]; exp_rw = rw; exp_wdata = wd;
            done = 1'b0;
            while (!done) begin
                i_address = $urandom; i_wdata = $urandom; i_rw = 1'($urandom);
                i_target_ready = NT'($urandom);
                i_target_ready[idx] = (n > delay) && (abort_at != n);
                if (abort_at == n) i_request = 1'b0;
                @(posedge clk); #1;
                if (abort_at == n) begin
                    exp_req = '0; done = 1'b1; aborted = 1'b1;
                end else if (n > delay) begin
                    exp_ready = 1'b1; exp_error = 1'b0; exp_rdata = rd_val; exp_req = '0; done = 1'b1;
                end else if (n == TO) begin
                    exp_ready = 1'b1; exp_error = 1'b1; exp_rdata = '0; exp_req = '0; done = 1'b1;
                end
                n++;
            end
        end
        last_lat = n - 1;
        last_rdata = o_rdata; last_err = o_error; last_rdy = o_ready;
        if (!aborted) begin
            for (int h = 0; h < hold; h++) begin
                i_target_ready = NT'($urandom);
                @(posedge clk); #1;
            end
            i_request = 1'b0;
            @(posedge clk); #1;
            exp_ready = 1'b0; exp_error = 1'b0;
        end
        i_target_ready = '0;
    endtask

    initial begin
        int d, ab, lim;
        i_reset = 1'b1; i_request = 1'b0; i_rw = 1'b0; i_address = '0; i_wdata = '0;
        i_target_rdata = '0; i_target_ready = '0;
        exp_ready = 1'b0; exp_error = 1'b0; exp_rw = 1'b0; exp_rdata = '0;
        exp_taddr = '0; exp_wdata = '0; exp_req = '0;

        @(posedge clk); #1;
        chk("rst_ready", 32'(o_ready), 32'h0);
        chk("rst_error", 32'(o_error), 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_treq",  32'(o_target_request), 32'h0);
        chk("rst_taddr", o_target_address, 32'h0);
        chk("rst_twdata", o_target_wdata, 32'h0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        chk_en = 1'b1;

        chk("model_dec_t1", decode(32'h00010004), 32'd1);
        chk("model_dec_unmapped", decode(32'h50000100), 32'hFFFFFFFF);

        do_txn(32'h00010004, 1'b0, 32'h0, 0, 0, 32'hDEADBEEF, 1);
        chk("t1_taddr", last_taddr, 32'h4);
        chk("t1_lat",   last_lat, 32'd1);
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);
        chk("t1_err",   32'(last_err), 32'h0);

        do_txn(32'h20000010, 1'b1, 32'h12345678, 5, 0, 32'hCAFEF00D, 0);
        chk("t2_treq",   32'(last_treq), 32'h8);
        chk("t2_twdata", last_twdata, 32'h12345678);
        chk("t2_trw",    32'(last_trw), 32'h1);
        chk("t2_lat",    last_lat, 32'd6);

        do_txn(32'h50000100, 1'b0, 32'h0, 0, 0, 32'h0, 2);
        chk("t3_treq",  32'(last_treq), 32'h0);
        chk("t3_rdy",   32'(last_rdy), 32'h1);
        chk("t3_err",   32'(last_err), 32'h1);
        chk("t3_rdata", last_rdata, 32'h0);

        do_txn(32'h10000040, 1'b0, 32'h0, 1000, 0, 32'h11111111, 0);
        chk("t4_lat",   last_lat, 32'd16);
        chk("t4_err",   32'(last_err), 32'h1);
        chk("t4_rdata", last_rdata, 32'h0);

        do_txn(32'h00000100, 1'b0, 32'h0, 0, 0, 32'h0BADCAFE, 0);
        chk("t5_ov_treq", 32'(last_ovreq), 32'h1);
        chk("t5_treq",    32'(last_treq), 32'h1);

        do_txn(32'h00010020, 1'b0, 32'h0, 10, 3, 32'h22222222, 0);
        chk("t6_abort_rdy",  32'(o_ready), 32'h0);
        chk("t6_abort_treq", 32'(o_target_request), 32'h0);
        do_txn(32'h00000010, 1'b0, 32'h0, 0, 0, 32'h33333333, 0);
        chk("t6_next_lat", last_lat, 32'd1);

        i_request = 1'b1; i_rw = 1'b1; i_address = 32'h10000008; i_wdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        chk("t7_treq", 32'(o_target_request), 32'h4);
        chk_en = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("t7_rst_treq",  32'(o_target_request), 32'h0);
        chk("t7_rst_rdy",   32'(o_ready), 32'h0);
        chk("t7_rst_rdata", o_rdata, 32'h0);
        chk("t7_rst_taddr", o_target_address, 32'h0);
        chk("t7_rst_rw",    32'(o_target_rw), 32'h0);
        i_request = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b0;
        exp_ready = 1'b0; exp_error = 1'b0; exp_req = '0;
        chk_en = 1'b1;
        do_txn(32'h0001ABCC, 1'b0, 32'h0, 2, 0, 32'h76543210, 0);
        chk("t7_after_rdata", last_rdata, 32'h76543210);
        chk("t7_after_lat",   last_lat, 32'd3);

        for (int k = 0; k < 80; k++) begin
            d = $urandom_range(0, 20);
            ab = 0;
            lim = (d < TO - 1) ? d : TO - 1;
            if (lim >= 1 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, lim);
            do_txn(pick_addr(), 1'($urandom), $urandom, d, ab, $urandom, $urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_router.md
# bus_router

Parametrised address-decoding bus router between one bus master (CPU_v2 bus port) and TARGETS slave devices. Replaces hand-written per-target select/mux assigns in the SoC top with a registered router. Adds an error response for unmapped addresses, a per-transaction timeout, and abort handling. Each target sees a base-relative address.

## Interface
- TARGETS, 4: number of slave ports (1..16).
- BASES, {TARGETS{32'h0}}: packed TARGETS×32 base addresses; target i uses bits [32*i+31:32*i].
- LIMITS, {TARGETS{32'h0}}: packed TARGETS×32 exclusive end addresses; target i hits when BASE_i <= addr < LIMIT_i.
- TIMEOUT, 1024: cycles in ACTIVE before forced error response; 0 disables the timeout.
- i_clock  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_request  in  1  master request, held until o_ready
- i_rw  in  1  1 = write
- i_address  in  32  master address
- i_wdata  in  32  write data
- o_rdata  out  32  read data, registered
- o_ready  out  1  transaction complete, registered
- o_error  out  1  valid with o_ready: unmapped or timed out
- o_target_request  out  TARGETS  one-hot request to the selected target
- o_target_rw  out  1  registered copy of i_rw
- o_target_address  out  32  i_address − BASE of the selected target, registered
- o_target_wdata  out  32  registered copy of i_wdata
- i_target_rdata  in  32×TARGETS  packed read data, target i at [32*i+31:32*i]
- i_target_ready  in  TARGETS  per-target ready

## Operation
- FSM states: IDLE, ACTIVE, RESPOND.
- IDLE:
  - i_request=1 → decode i_address. If any region hits, the lowest index wins (overlap priority). Latch the index, offset address, rw, and wdata, then go to ACTIVE.
  - No region hits → go to RESPOND with o_error=1 and o_rdata=0.
- ACTIVE:
  - o_target_request[idx]=1; all other bits 0.
  - i_target_ready[idx]=1 → capture i_target_rdata[idx] into o_rdata, o_error=0, go to RESPOND. o_target_request drops in the same cycle.
  - Readies from non-selected targets are ignored.
  - Timeout counter starts at 0 on entry to ACTIVE and increments every cycle. When it reaches TIMEOUT−1 without ready → o_error=1, o_rdata=0, go to RESPOND.
  - i_request drops (abort) → return to IDLE. Drop the target request; no o_ready is produced.
- RESPOND:
  - o_ready=1 while i_request=1.
  - When i_request=0 → clear o_ready and o_error, go to IDLE.
  - A new request can be accepted only after one IDLE cycle.
- Writes to unmapped addresses get the same error response as reads; no target sees them.
- Address arithmetic is 32-bit unsigned; the subtraction wraps modulo 2^32.

## Timing
- Reset (asynchronous): state=IDLE; o_ready=0, o_error=0, o_rdata=0, o_target_request=0, o_target_rw=0, o_target_address=0, o_target_wdata=0; timeout counter=0.
- Reset asserted mid-transaction drops o_target_request immediately and discards the transaction.
- Cycle numbering: i_request first sampled at edge E0.
  - o_target_request goes high after E0.
  - Zero-wait target (ready already high when requested): captured at E1, o_ready high after E1.
  - Minimum latency: 2 edges.
  - Target with ready after k ACTIVE cycles: o_ready high after E(k+1).
- Unmapped address: o_ready and o_error high after E0 (1 edge).
- Timeout: o_ready and o_error high TIMEOUT edges after entering ACTIVE.
- o_target_rw, o_target_address and o_target_wdata are stable throughout ACTIVE.
- Master inputs are not re-sampled after E0.

## Test plan
- Map {0x0–0x10000, 0x10000–0x20000, 0x10000000–0x20000000, 0x20000000–0x40000000}. Read 0x00010004, target 1 ready immediately with rdata 0xDEADBEEF → o_target_address=0x4, o_ready after 2 edges, o_rdata=0xDEADBEEF, o_error=0.
- Write 0x20000010, wdata 0x12345678, target 3 ready after 5 cycles → o_target_request=4'b1000, o_target_wdata=0x12345678, o_target_rw=1, o_ready after 6 edges.
- Read 0x50000100 (unmapped) → no target request, o_ready=1 and o_error=1 after 1 edge, o_rdata=0. Both drop the cycle after i_request=0.
- TIMEOUT=16, target 2 never ready → o_target_request[2] high 16 cycles, then o_ready=1, o_error=1, o_rdata=0.
- Overlapping regions 0 and 1 both contain 0x100 → target 0 selected. Separately, drop i_request during ACTIVE → request drops, no o_ready, FSM back in IDLE.
- Assert i_reset asynchronously mid-ACTIVE → all outputs 0 before the next edge. Then a normal read completes correctly after reset release.
